// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: one power-of-two stage (1,2,4,8...) applied per cycle, amount walked LSB-first.
// Latency: fixed CNT_W cycles after the accepting edge; done pulses with Out valid in the following cycle.
// Backpressure: start is ignored while busy=1; a start held in the done cycle is accepted back-to-back.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {OP_ROL = 2'b00, OP_SLL = 2'b01, OP_ROR = 2'b10, OP_SRL = 2'b11} op_t;

    typedef struct packed {
        logic [WIDTH-1:0] work;
        logic [CNT_W-1:0] cnt;
        op_t              op;
    } job_t;

    state_t           state;
    job_t             job;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] stage_dat;
    int unsigned      sh;

    // A shift by the full WIDTH yields zero, so sh=0 rotates cleanly to the identity.
    always_comb begin
        sh        = job.cnt[idx] ? (32'd1 << idx) : 32'd0;
        stage_dat = job.work;
        case (job.op)
            OP_ROL:  stage_dat = (job.work << sh) | (job.work >> (32'(WIDTH) - sh));
            OP_SLL:  stage_dat = job.work << sh;
            OP_ROR:  stage_dat = (job.work >> sh) | (job.work << (32'(WIDTH) - sh));
            OP_SRL:  stage_dat = job.work >> sh;
            default: stage_dat = job.work;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            job   <= '0;
            idx   <= '0;
            Out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        job.work <= In;
                        job.cnt  <= Cnt;
                        job.op   <= op_t'(Op);
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    job.work <= stage_dat;
                    idx      <= idx + IDX_W'(1);
                    if (idx == IDX_W'(CNT_W - 1)) begin
                        Out   <= stage_dat;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, handshake/reset sequences, random ops vs model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .In(In), .Cnt(Cnt), .Op(Op),
        .Out(Out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  o;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: a single whole-amount shift, rotates done through a doubled word.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o);
        logic [31:0] d;
        d = {a, a};
        case (o)
            2'b00:   model = 16'((d << c) >> 16);
            2'b01:   model = a << c;
            2'b10:   model = 16'(d >> c);
            default: model = a >> c;
        endcase
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Drives one op from a negedge and checks latency, result and single done pulse.
    task automatic do_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                         input logic [15:0] exp, input string name);
        int n;
        @(negedge clk);
        In = a; Cnt = c; Op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
        check({name, " busy"}, busy, 1);
        wait_done(n);
        check({name, " latency"}, n, 4);
        check({name, " out"}, Out, exp);
        @(negedge clk);
        check({name, " done_once"}, done, 0);
        check({name, " out_hold"}, Out, exp);
    endtask

    initial begin
        int n;
        int pulses;
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  o;

        vecs[0] = '{16'h8001, 4'd5,  2'b11, 16'h0400};
        vecs[1] = '{16'h8001, 4'd1,  2'b00, 16'h0003};
        vecs[2] = '{16'h0001, 4'd15, 2'b10, 16'h0002};
        vecs[3] = '{16'hFFFF, 4'd15, 2'b01, 16'h8000};
        vecs[4] = '{16'h1234, 4'd0,  2'b01, 16'h1234};
        vecs[5] = '{16'h1234, 4'd4,  2'b00, 16'h2341};
        vecs[6] = '{16'h8001, 4'd4,  2'b10, 16'h1800};
        vecs[7] = '{16'hFFFF, 4'd15, 2'b11, 16'h0001};
        vecs[8] = '{16'hA5C3, 4'd0,  2'b10, 16'hA5C3};
        vecs[9] = '{16'h00F0, 4'd2,  2'b01, 16'h03C0};

        rst = 1'b1; start = 1'b0; In = '0; Cnt = '0; Op = '0;
        #1;
        check("reset_out", Out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].c, vecs[i].o, vecs[i].exp, $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a cycle clears outputs immediately.
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", Out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // start held through busy is ignored; still held in done cycle it launches op 2.
        @(negedge clk);
        In = 16'h8001; Cnt = 4'd5; Op = 2'b11; start = 1'b1;
        @(negedge clk);
        In = 16'h00F0; Cnt = 4'd2; Op = 2'b01;
        wait_done(n);
        check("b2b first latency", n, 4);
        check("b2b first out", Out, 16'h0400);
        @(negedge clk);
        start = 1'b0;
        check("b2b second accepted", busy, 1);
        check("b2b done single", done, 0);
        wait_done(n);
        check("b2b second latency", n, 4);
        check("b2b second out", Out, 16'h03C0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("b2b no extra done", pulses, 0);

        // Reset during the second SHIFT cycle abandons the op with no done pulse.
        @(negedge clk);
        In = 16'h1234; Cnt = 4'd3; Op = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst busy", busy, 0);
        check("mid_rst out", Out, 0);
        check("mid_rst done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("mid_rst abandoned", pulses, 0);
        do_op(16'hBEEF, 4'd7, 2'b10, model(16'hBEEF, 4'd7, 2'b10), "post_rst");

        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            c = 4'($urandom);
            o = 2'($urandom);
            if (($urandom % 4) == 0) c = 4'd15;
            do_op(a, c, o, model(a, c, o), $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
